instr_fetch: RTL and testbench

Instruction fetch unit: the initiator that drives the address side of the combinational, byte-addressed instruction ROM and delivers fetched words to decode. Holds the fetch PC, reads one 32-bit word per cycle, buffers words with their PCs in a small FIFO, and presents them through a valid/ready handshake. Sits between the instruction ROM and the decode stage; accepts PC redirects from branch/jump resolution.

---
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the combinational ROM address from the fetch PC
// and buffers fetched {pc, instr} pairs in a small FIFO toward decode.
module instr_fetch #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr_out,
  output logic [ADDRESS_WIDTH-1:0] pc_out,
  output logic                     misalign_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [PW-1:0]            rdPtr_q, rdPtr_d;
  logic [PW-1:0]            wrPtr_q, wrPtr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     misalign_q, misalign_d;
  logic [ADDRESS_WIDTH-1:0] pcMem_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    instrMem_q [FIFO_DEPTH];

  logic pop;
  logic push;
  logic full;

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = (count_q != '0) & instr_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a word.
  assign push = ~redirect_valid & (~full | pop);

  always_comb begin
    fetchPc_d  = fetchPc_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      fetchPc_d  = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
      rdPtr_d    = '0;
      wrPtr_d    = '0;
      count_d    = '0;
      misalign_d = misalign_q | (redirect_target[1:0] != 2'b00);
    end else begin
      if (push) begin
        wrPtr_d   = wrPtr_q + PW'(1);
        fetchPc_d = fetchPc_q + ADDRESS_WIDTH'(4);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q  <= RESET_PC;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcMem_q[i]    <= '0;
        instrMem_q[i] <= '0;
      end
    end else if (push) begin
      pcMem_q[wrPtr_q]    <= fetchPc_q;
      instrMem_q[wrPtr_q] <= rom_instr;
    end
  end

  assign rom_addr     = fetchPc_q;
  assign instr_valid  = (count_q != '0);
  assign instr_out    = instrMem_q[rdPtr_q];
  assign pc_out       = pcMem_q[rdPtr_q];
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of the fetch stream.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  entry_t      modelQ[$];
  logic [31:0] modelPc  = 32'h0;
  logic        modelErr = 1'b0;

  instr_fetch #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC(32'h0),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rom_addr(rom_addr),
    .rom_instr(rom_instr),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // ROM contents: word k (address 4k) holds (k+1)*0x11111111, distinct for every k.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11111111;
  endfunction

  assign rom_instr = romWord(rom_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] target);
    @(negedge clk);
    instr_ready     = ready;
    redirect_valid  = redir;
    redirect_target = target;
  endtask

  task automatic doReset(input logic readyDuring);
    @(negedge clk);
    rst            = 1'b1;
    instr_ready    = readyDuring;
    redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Model: the fetch stream is a queue of {pc, word}; decode pops the front and
  // the fetcher appends the next sequential word whenever there is room.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        modelQ.delete();
        modelPc  = 32'h0;
        modelErr = 1'b0;
      end else if (redirect_valid) begin
        if (redirect_target[1:0] != 2'b00) modelErr = 1'b1;
        modelQ.delete();
        modelPc = redirect_target & 32'hFFFF_FFFC;
      end else begin
        if (modelQ.size() != 0 && instr_ready) void'(modelQ.pop_front());
        if (modelQ.size() < DEPTH) begin
          modelQ.push_back('{pc: modelPc, instr: romWord(modelPc)});
          modelPc = modelPc + 32'd4;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        checkOutput("model_valid", {31'b0, instr_valid}, {31'b0, modelQ.size() != 0});
        checkOutput("model_rom_addr", rom_addr, modelPc);
        checkOutput("model_misalign", {31'b0, misalign_err}, {31'b0, modelErr});
        if (modelQ.size() != 0 && instr_valid) begin
          checkOutput("model_pc_out", pc_out, modelQ[0].pc);
          checkOutput("model_instr_out", instr_out, modelQ[0].instr);
        end
      end
    end
  end

  initial begin
    rst             = 1'b0;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("reset_rom_addr", rom_addr, 32'h0);
    checkOutput("reset_pc_out", pc_out, 32'h0);
    checkOutput("reset_instr_out", instr_out, 32'h0);
    checkOutput("reset_misalign", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming from reset with decode always ready.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stream_valid", {31'b0, instr_valid}, 32'h1);
      checkOutput("stream_pc", pc_out, 32'(k * 4));
      checkOutput("stream_word", instr_out, 32'(k + 1) * 32'h11111111);
    end

    // Back-pressure: FIFO saturates and the fetch address stalls.
    doReset(1'b0);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stall_rom_addr", rom_addr, 32'h8);
    checkOutput("stall_head_pc", pc_out, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("release_pc", pc_out, 32'(k * 4));
    end

    // Redirect while full: one bubble then the target stream.
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_bubble", {31'b0, instr_valid}, 32'h0);
    checkOutput("redir_rom_addr", rom_addr, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_pc", pc_out, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_next_pc", pc_out, 32'h44);

    // Misaligned target is aligned down and latches a sticky error.
    applyStimulus(1'b1, 1'b1, 32'h42);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("misalign_rom_addr", rom_addr, 32'h40);
    checkOutput("misalign_set", {31'b0, misalign_err}, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("misalign_sticky", {31'b0, misalign_err}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("after_misalign_pc", pc_out, 32'h100);

    // Fetch address wraps from the top of the address space to zero.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_top_pc", pc_out, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrap_zero_pc", pc_out, 32'h0);
    checkOutput("wrap_zero_word", instr_out, 32'h11111111);

    // Reset mid-stream with two entries buffered.
    doReset(1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("prerst_valid", {31'b0, instr_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("midrst_rom_addr", rom_addr, 32'h0);
    checkOutput("midrst_misalign", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    instr_ready = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("restart_pc", pc_out, 32'(k * 4));
      checkOutput("restart_word", instr_out, 32'(k + 1) * 32'h11111111);
    end

    // Randomized traffic, checked by the per-cycle model comparison.
    for (int k = 0; k < 400; k++) begin
      logic        rdy;
      logic        rdr;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 9) < 7);
      rdr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = 32'($urandom_range(0, 511));
      if (k == 200) doReset(1'b1);
      applyStimulus(rdy, rdr, tgt);
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
